// File: rtl/uparc_ibuf_predecode.sv
// Instruction buffer between fetch and decode: a FWFT FIFO of {pc, instr}
// pairs, each predecoded (control transfer, static target, LSU) on push.
module uparc_ibuf_predecode #(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output logic                   o_full,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic                   o_pd_cti,
  output logic                   o_pd_static,
  output logic [ADDR_WIDTH-1:0]  o_pd_target,
  output logic                   o_pd_lsu,
  output logic [CNT_WIDTH-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic [DEPTH-1:0]     entry_valid;

  logic [ADDR_WIDTH-1:0]  pc_mem     [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0]  target_mem [DEPTH];
  logic [DEPTH-1:0]       cti_mem;
  logic [DEPTH-1:0]       static_mem;
  logic [DEPTH-1:0]       lsu_mem;

  logic empty;
  logic full;
  logic pop_ok;
  logic push_ok;
  logic head_live;

  logic [5:0]            op;
  logic [4:0]            rt;
  logic [5:0]            func;
  logic [ADDR_WIDTH-1:0] pc4;
  logic [ADDR_WIDTH-1:0] br_off;
  logic                  pd_cti;
  logic                  pd_static;
  logic [ADDR_WIDTH-1:0] pd_target;
  logic                  pd_lsu;

  assign empty   = (count == '0);
  assign full    = (count == CNT_WIDTH'(DEPTH));
  assign pop_ok  = i_pop && !empty;
  assign push_ok = i_push && (!full || pop_ok);

  assign op     = i_instr[31:26];
  assign rt     = i_instr[20:16];
  assign func   = i_instr[5:0];
  assign pc4    = i_pc + ADDR_WIDTH'(4);
  assign br_off = {{(ADDR_WIDTH-18){i_instr[15]}}, i_instr[15:0], 2'b00};

  always_comb begin
    pd_cti    = 1'b0;
    pd_static = 1'b0;
    pd_target = '0;
    pd_lsu    = 1'b0;
    case (op)
      6'd2, 6'd3: begin
        pd_cti    = 1'b1;
        pd_static = 1'b1;
        pd_target = {pc4[ADDR_WIDTH-1:28], i_instr[25:0], 2'b00};
      end
      6'd4, 6'd5, 6'd6, 6'd7: begin
        pd_cti    = 1'b1;
        pd_static = 1'b1;
        pd_target = pc4 + br_off;
      end
      6'd1: begin
        if (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17) begin
          pd_cti    = 1'b1;
          pd_static = 1'b1;
          pd_target = pc4 + br_off;
        end
      end
      6'd0: begin
        if (func == 6'd8 || func == 6'd9) begin
          pd_cti = 1'b1;
        end
      end
      6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd40, 6'd41, 6'd43: begin
        pd_lsu = 1'b1;
      end
      default: ;
    endcase
  end

  // Flush outranks push/pop; a simultaneous push+pop reuses the popped slot when full.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else if (i_flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (pop_ok) begin
        entry_valid[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + PTR_W'(1);
      end
      if (push_ok) begin
        entry_valid[wr_ptr] <= 1'b1;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count <= count + CNT_WIDTH'(1);
      end else if (pop_ok && !push_ok) begin
        count <= count - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !i_flush) begin
      pc_mem[wr_ptr]     <= i_pc;
      instr_mem[wr_ptr]  <= i_instr;
      target_mem[wr_ptr] <= pd_target;
      cti_mem[wr_ptr]    <= pd_cti;
      static_mem[wr_ptr] <= pd_static;
      lsu_mem[wr_ptr]    <= pd_lsu;
    end
  end

  assign head_live   = !empty && entry_valid[rd_ptr];
  assign o_full      = full;
  assign o_valid     = !empty;
  assign o_count     = count;
  assign o_instr     = head_live ? instr_mem[rd_ptr]  : '0;
  assign o_pc        = head_live ? pc_mem[rd_ptr]     : '0;
  assign o_pd_target = head_live ? target_mem[rd_ptr] : '0;
  assign o_pd_cti    = head_live && cti_mem[rd_ptr];
  assign o_pd_static = head_live && static_mem[rd_ptr];
  assign o_pd_lsu    = head_live && lsu_mem[rd_ptr];

endmodule

// File: tb/tb_uparc_ibuf_predecode.sv
// Self-checking bench for uparc_ibuf_predecode: directed vector table,
// async-reset sequence and randomized traffic against a queue model.
module tb_uparc_ibuf_predecode;

  localparam int DEPTH = 4;

  localparam logic [31:0] I_J    = 32'h0800_0040;
  localparam logic [31:0] I_BEQ  = 32'h1000_FFFF;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_LW   = 32'h8C43_0004;
  localparam logic [31:0] I_SB   = 32'hA043_0000;
  localparam logic [31:0] I_ADDU = 32'h0043_1021;

  logic        clk;
  logic        nrst;
  logic        i_flush;
  logic        i_push;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic        o_full;
  logic        i_pop;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_pd_cti;
  logic        o_pd_static;
  logic [31:0] o_pd_target;
  logic        o_pd_lsu;
  logic [2:0]  o_count;

  uparc_ibuf_predecode #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .i_flush(i_flush), .i_push(i_push),
    .i_pc(i_pc), .i_instr(i_instr), .o_full(o_full), .i_pop(i_pop),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
    .o_pd_cti(o_pd_cti), .o_pd_static(o_pd_static),
    .o_pd_target(o_pd_target), .o_pd_lsu(o_pd_lsu), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush, push, pop;
    logic [31:0] pc, instr;
    int          cnt;
    logic        valid, full, cti, stat, lsu;
    logic [31:0] hpc, hinstr, tgt;
  } vec_t;

  typedef struct {
    logic [31:0] pc, instr;
  } entry_t;

  vec_t   vecs[$];
  entry_t model_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Predecode derived straight from the MIPS-I field rules with plain arithmetic.
  task automatic ref_pd(input logic [31:0] pc, input logic [31:0] ins,
                        output logic cti, output logic stat,
                        output logic [31:0] tgt, output logic lsu);
    int unsigned op, rt, fn;
    int          imm;
    op = ins >> 26;
    rt = (ins >> 16) & 31;
    fn = ins & 63;
    imm = int'(ins & 32'hFFFF);
    if (imm >= 32768) imm = imm - 65536;
    cti = 0; stat = 0; tgt = 0; lsu = 0;
    if (op == 2 || op == 3) begin
      cti = 1; stat = 1;
      tgt = ((pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    end else if ((op >= 4 && op <= 7) ||
                 (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17))) begin
      cti = 1; stat = 1;
      tgt = pc + 32'd4 + 32'(imm * 4);
    end else if (op == 0 && (fn == 8 || fn == 9)) begin
      cti = 1;
    end else if ((op >= 32 && op <= 37) || op == 40 || op == 41 || op == 43) begin
      lsu = 1;
    end
  endtask

  task automatic model_step(input logic f, input logic pu, input logic po,
                            input logic [31:0] pc, input logic [31:0] ins);
    bit pop_ok, push_ok;
    entry_t e;
    if (f) begin
      model_q.delete();
    end else begin
      pop_ok  = po && model_q.size() > 0;
      push_ok = pu && (model_q.size() < DEPTH || pop_ok);
      if (pop_ok) void'(model_q.pop_front());
      if (push_ok) begin
        e.pc = pc; e.instr = ins;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic f, input logic pu, input logic po,
                               input logic [31:0] pc, input logic [31:0] ins);
    i_flush = f; i_push = pu; i_pop = po; i_pc = pc; i_instr = ins;
    @(posedge clk);
    model_step(f, pu, po, pc, ins);
    #1;
    i_flush = 0; i_push = 0; i_pop = 0;
  endtask

  task automatic checkOutput(input string tag);
    logic cti, stat, lsu;
    logic [31:0] tgt, epc, eins;
    int n;
    n = model_q.size();
    if (n > 0) begin
      epc = model_q[0].pc; eins = model_q[0].instr;
      ref_pd(epc, eins, cti, stat, tgt, lsu);
    end else begin
      epc = 0; eins = 0; cti = 0; stat = 0; tgt = 0; lsu = 0;
    end
    chk({tag, " count"},  32'(o_count),  32'(n));
    chk({tag, " valid"},  32'(o_valid),  32'(n > 0));
    chk({tag, " full"},   32'(o_full),   32'(n == DEPTH));
    chk({tag, " pc"},     o_pc,          epc);
    chk({tag, " instr"},  o_instr,       eins);
    chk({tag, " cti"},    32'(o_pd_cti), 32'(cti));
    chk({tag, " static"}, 32'(o_pd_static), 32'(stat));
    chk({tag, " target"}, o_pd_target,   tgt);
    chk({tag, " lsu"},    32'(o_pd_lsu), 32'(lsu));
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("vec%0d", idx);
    chk({t, " count"},  32'(o_count),     32'(v.cnt));
    chk({t, " valid"},  32'(o_valid),     32'(v.valid));
    chk({t, " full"},   32'(o_full),      32'(v.full));
    chk({t, " pc"},     o_pc,             v.hpc);
    chk({t, " instr"},  o_instr,          v.hinstr);
    chk({t, " cti"},    32'(o_pd_cti),    32'(v.cti));
    chk({t, " static"}, 32'(o_pd_static), 32'(v.stat));
    chk({t, " target"}, o_pd_target,      v.tgt);
    chk({t, " lsu"},    32'(o_pd_lsu),    32'(v.lsu));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int unsigned sel;
    r = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0: r[31:26] = 6'd0;
      1: begin r[31:26] = 6'd0; r[5:0] = 6'($urandom_range(8, 9)); end
      2: r[31:26] = 6'd1;
      3: r[31:26] = 6'($urandom_range(2, 3));
      4: r[31:26] = 6'($urandom_range(4, 7));
      5: r[31:26] = 6'($urandom_range(32, 43));
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    nrst = 0; i_flush = 0; i_push = 0; i_pop = 0; i_pc = 0; i_instr = 0;
    #12;
    checkOutput("reset");
    @(negedge clk);
    nrst = 1;
    @(negedge clk);

    //            flush push pop pc            instr   cnt v f cti st lsu hpc           hinstr  tgt
    vecs.push_back('{0, 1, 0, 32'h100,       I_ADDU, 1, 1, 0, 0, 0, 0, 32'h100,       I_ADDU, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h104,       I_LW,   2, 1, 0, 0, 0, 0, 32'h100,       I_ADDU, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h108,       I_SB,   3, 1, 0, 0, 0, 0, 32'h100,       I_ADDU, 32'h0});
    vecs.push_back('{0, 0, 1, 32'h0,         32'h0,  2, 1, 0, 0, 0, 1, 32'h104,       I_LW,   32'h0});
    vecs.push_back('{0, 0, 1, 32'h0,         32'h0,  1, 1, 0, 0, 0, 1, 32'h108,       I_SB,   32'h0});
    vecs.push_back('{0, 0, 1, 32'h0,         32'h0,  0, 0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h0});
    vecs.push_back('{0, 0, 1, 32'h0,         32'h0,  0, 0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h0});
    vecs.push_back('{0, 1, 0, 32'h1000_0000, I_J,    1, 1, 0, 1, 1, 0, 32'h1000_0000, I_J,    32'h1000_0100});
    vecs.push_back('{0, 1, 0, 32'h200,       I_BEQ,  2, 1, 0, 1, 1, 0, 32'h1000_0000, I_J,    32'h1000_0100});
    vecs.push_back('{0, 1, 0, 32'h300,       I_JR,   3, 1, 0, 1, 1, 0, 32'h1000_0000, I_J,    32'h1000_0100});
    vecs.push_back('{0, 1, 0, 32'h304,       I_ADDU, 4, 1, 1, 1, 1, 0, 32'h1000_0000, I_J,    32'h1000_0100});
    vecs.push_back('{0, 1, 0, 32'h308,       I_LW,   4, 1, 1, 1, 1, 0, 32'h1000_0000, I_J,    32'h1000_0100});
    vecs.push_back('{0, 1, 1, 32'h30C,       I_SB,   4, 1, 1, 1, 1, 0, 32'h200,       I_BEQ,  32'h200});
    vecs.push_back('{0, 0, 1, 32'h0,         32'h0,  3, 1, 0, 1, 0, 0, 32'h300,       I_JR,   32'h0});
    vecs.push_back('{0, 0, 1, 32'h0,         32'h0,  2, 1, 0, 0, 0, 0, 32'h304,       I_ADDU, 32'h0});
    vecs.push_back('{0, 0, 1, 32'h0,         32'h0,  1, 1, 0, 0, 0, 1, 32'h30C,       I_SB,   32'h0});
    vecs.push_back('{0, 1, 1, 32'h400,       I_LW,   1, 1, 0, 0, 0, 1, 32'h400,       I_LW,   32'h0});
    vecs.push_back('{0, 1, 0, 32'h404,       I_ADDU, 2, 1, 0, 0, 0, 1, 32'h400,       I_LW,   32'h0});
    vecs.push_back('{0, 1, 0, 32'h408,       I_ADDU, 3, 1, 0, 0, 0, 1, 32'h400,       I_LW,   32'h0});
    vecs.push_back('{1, 1, 1, 32'h40C,       I_LW,   0, 0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h0});
    vecs.push_back('{0, 0, 1, 32'h0,         32'h0,  0, 0, 0, 0, 0, 0, 32'h0,         32'h0,  32'h0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].flush, vecs[i].push, vecs[i].pop, vecs[i].pc, vecs[i].instr);
      check_vec(i, vecs[i]);
    end

    // Asynchronous reset in mid-cycle with two entries buffered.
    applyStimulus(0, 1, 0, 32'h500, I_J);
    applyStimulus(0, 1, 0, 32'h504, I_LW);
    checkOutput("pre_areset");
    #2;
    nrst = 0;
    model_q.delete();
    #1;
    checkOutput("areset_now");
    @(negedge clk);
    nrst = 1;
    #1;
    checkOutput("areset_release");
    applyStimulus(0, 0, 1, 32'h0, 32'h0);
    checkOutput("pop_empty");

    for (int c = 0; c < 400; c++) begin
      logic f, pu, po;
      logic [31:0] pc;
      f  = ($urandom_range(0, 29) == 0);
      pu = ($urandom_range(0, 9) < 6);
      po = ($urandom_range(0, 9) < 5);
      pc = $urandom & 32'hFFFF_FFFC;
      applyStimulus(f, pu, po, pc, rand_instr());
      checkOutput($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
